dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH, default 3072, number of 32-bit storage words; the valid byte range is 0 to DEPTH*4-1.
REQ-002 Parameter LATENCY, default 2, number of cycles from request acceptance to ack; the legal range is 1..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  request from the M-stage initiator; held high until ack.
REQ-006 we  input  1  1 means write, 0 means read; sampled at acceptance.
REQ-007 addr  input  32  byte address; sampled at acceptance.
REQ-008 be  input  4  byte enables for writes; be[i] covers wdata[8i+7:8i]; sampled at acceptance.
REQ-009 wdata  input  32  write data; sampled at acceptance.
REQ-010 busy  output  1  high while a request is accepted but not yet acked; the initiator stalls the pipeline on req&~ack.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  read data; valid only while ack=1; 0 otherwise.
REQ-013 err  output  1  asserted with ack when the latched request was illegal.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-015 IDLE with req=1: latch we/addr/be/wdata, load the counter with LATENCY-1, and go to WAIT; if LATENCY=1, go directly to RESP.
REQ-016 IDLE with req=0: remain in IDLE; no state change.
REQ-017 WAIT: decrement the counter each cycle and go to RESP in the cycle after the counter reads 0; input changes in WAIT are ignored.
REQ-018 RESP: ack=1 for exactly one cycle, then return to IDLE.
- req is ignored in RESP.
- The earliest next acceptance is the cycle after ack.
- A back-to-back request therefore costs LATENCY+1 cycles.
REQ-019 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-020 A request SHALL be illegal if addr[1:0]!=0 or addr>DEPTH*4-1.
REQ-021 Illegal request: ack=1, err=1, rdata=0, no storage change.
REQ-022 Legal read: rdata = word[addr[31:2]] as held at the RESP cycle.
REQ-023 Legal write: update only the bytes whose be bit is 1, on the rising edge ending the RESP cycle; rdata=0 during the write ack.
REQ-024 A write with be=4'b0000 SHALL complete normally with ack=1, err=0, and no storage change.
REQ-025 A read immediately following a write to the same word SHALL return the updated data.
REQ-026 Outputs SHALL be registered or derived only from state; there is no combinational path from any input to ack, busy, rdata, or err.

Reset
REQ-027 rst=0 SHALL asynchronously force the state to IDLE, the counter to 0, all latched request fields to 0, and every storage word to 0.
REQ-028 While rst=0: busy=0, ack=0, err=0, rdata=0.
REQ-029 If rst asserts during WAIT or RESP, the pending request SHALL be discarded with no write and no ack.
REQ-030 After rst deasserts, the first rising edge with req=1 SHALL accept a request.

Verification
REQ-031 LATENCY=2. Write addr=0x10, be=4'hF, wdata=0x12345678, then read addr=0x10 -> ack 2 cycles after acceptance each time; read rdata=0x12345678, err=0.
REQ-032 Partial write. Word 0x20 holds 0xAABBCCDD; write be=4'b0101, wdata=0x11223344; then read -> rdata=0xAA22CC44.
REQ-033 Illegal requests. Read addr=0x3002 -> ack=1, err=1, rdata=0. Write addr=0x3000, wdata=0xFFFFFFFF -> err=1; a subsequent read of 0x2FFC returns its prior value.
REQ-034 Back-to-back. Hold req=1 across two reads with LATENCY=3 -> acks separated by exactly 4 cycles; busy low for exactly one cycle between them.
REQ-035 Reset mid-operation. Issue write addr=0x40, wdata=0x5A5A5A5A; pull rst low during WAIT -> no ack; after release, read of 0x40 returns 0.
REQ-036 LATENCY=1. Read accepted at cycle N -> ack at cycle N+1; busy high only in cycle N+1.

Source files
------------

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - fixed-latency data-memory responder with byte-enable writes
module dm_responder #(
    parameter int DEPTH   = 3072,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LAST_BYTE = 32'(DEPTH * 4 - 1);
    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            lat_we, lat_err;
    logic [AW-1:0]   lat_idx;
    logic [3:0]      lat_be;
    logic [31:0]     lat_wdata;
    logic [31:0]     mem [DEPTH];
    logic            accept, illegal, write_go;

    assign accept   = (state == IDLE) && req;
    assign illegal  = (addr[1:0] != 2'b00) || (addr > LAST_BYTE);
    assign write_go = (state == RESP) && lat_we && !lat_err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (req) begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                // Last WAIT cycle is the one where the counter steps down to 0.
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1)
                    state_nxt = RESP;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_we    <= we;
                lat_err   <= illegal;
                // Park illegal requests on word 0 so the read mux never goes out of range.
                lat_idx   <= illegal ? '0 : addr[AW+1:2];
                lat_be    <= be;
                lat_wdata <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (write_go) begin
            for (int b = 0; b < 4; b++)
                if (lat_be[b])
                    mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
    end

    assign busy  = (state != IDLE);
    assign ack   = (state == RESP);
    assign err   = ack && lat_err;
    assign rdata = (ack && !lat_we && !lat_err) ? mem[lat_idx] : '0;
endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder at LATENCY 1, 2 and 3
module tb_dm_responder;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       req, we, busy, ack, err;
    logic [2:0][31:0] addr, wdata, rdata;
    logic [2:0][3:0]  be;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_responder #(.DEPTH(3072), .LATENCY(g + 1)) u_dut (
            .clk   (clk),
            .rst   (rst_n),
            .req   (req[g]),
            .we    (we[g]),
            .addr  (addr[g]),
            .be    (be[g]),
            .wdata (wdata[g]),
            .busy  (busy[g]),
            .ack   (ack[g]),
            .rdata (rdata[g]),
            .err   (err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty_on_ack", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_err"}, 32'(err[k]), 32'(e.exp_err));
        check({e.tag, "_rdata"}, rdata[k], e.exp_rdata);
    endtask

    task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic e_err, input logic [31:0] e_rd,
                          input string tag);
        int  n;
        bit  got;
        exp_t e;
        e.tag = tag; e.exp_err = e_err; e.exp_rdata = e_rd;
        sb.push_back(e);
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        check({tag, "_busy_idle"}, 32'(busy[k]), 32'd0);
        @(posedge clk);
        n = 0; got = 0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (ack[k]) got = 1;
        end
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(k + 1));
        if (got) begin
            check({tag, "_busy_ack"}, 32'(busy[k]), 32'd1);
            pop_check(k);
        end else begin
            void'(sb.pop_front());
        end
        req[k] = 1'b0;
        @(negedge clk);
        check({tag, "_ack_one_cycle"}, 32'(ack[k]), 32'd0);
        check({tag, "_busy_after"}, 32'(busy[k]), 32'd0);
    endtask

    initial begin
        int   n, acks, lowcnt;
        int   ack_t [2];
        bit   stray;
        exp_t e;

        rst_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_busy", 32'(busy[k]), 32'd0);
            check("reset_ack", 32'(ack[k]), 32'd0);
            check("reset_err", 32'(err[k]), 32'd0);
            check("reset_rdata", rdata[k], 32'd0);
        end
        rst_n = 1'b1;

        // LATENCY=2: full write then read back
        do_req(1, 1, 32'h10, 4'hF, 32'h12345678, 0, 32'h0, "wr10");
        do_req(1, 0, 32'h10, 4'h0, 32'h0, 0, 32'h12345678, "rd10");
        // partial writes and the be=0 no-op
        do_req(1, 1, 32'h20, 4'hF, 32'hAABBCCDD, 0, 32'h0, "wr20");
        do_req(1, 1, 32'h20, 4'b0101, 32'h11223344, 0, 32'h0, "wr20_part");
        do_req(1, 0, 32'h20, 4'h0, 32'h0, 0, 32'hAA22CC44, "rd20_part");
        do_req(1, 1, 32'h20, 4'b0000, 32'hFFFFFFFF, 0, 32'h0, "wr20_be0");
        do_req(1, 0, 32'h20, 4'h0, 32'h0, 0, 32'hAA22CC44, "rd20_be0");
        // illegal requests and the top legal word
        do_req(1, 1, 32'h2FFC, 4'hF, 32'hCAFEF00D, 0, 32'h0, "wr_top");
        do_req(1, 0, 32'h3002, 4'h0, 32'h0, 1, 32'h0, "rd_ill");
        do_req(1, 1, 32'h3000, 4'hF, 32'hFFFFFFFF, 1, 32'h0, "wr_ill_range");
        do_req(1, 1, 32'h2FFD, 4'hF, 32'hFFFFFFFF, 1, 32'h0, "wr_ill_align");
        do_req(1, 0, 32'h2FFC, 4'h0, 32'h0, 0, 32'hCAFEF00D, "rd_top");

        // LATENCY=3: back-to-back reads with req held high
        do_req(2, 1, 32'h8, 4'hF, 32'h0BADBEEF, 0, 32'h0, "wr8_l3");
        for (int i = 0; i < 2; i++) begin
            e.tag = (i == 0) ? "b2b_rd0" : "b2b_rd1"; e.exp_err = 0; e.exp_rdata = 32'h0BADBEEF;
            sb.push_back(e);
        end
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h8; be[2] = 4'h0;
        n = 0; acks = 0; lowcnt = 0; ack_t[0] = 0; ack_t[1] = 0;
        while (n < 40 && acks < 2) begin
            @(negedge clk);
            n++;
            if (ack[2]) begin
                ack_t[acks] = n;
                acks++;
                pop_check(2);
                if (acks == 2) req[2] = 1'b0;
            end else if (acks == 1 && !busy[2]) begin
                lowcnt++;
            end
        end
        check("b2b_acks", 32'(acks), 32'd2);
        check("b2b_first_latency", 32'(ack_t[0]), 32'd3);
        check("b2b_spacing", 32'(ack_t[1] - ack_t[0]), 32'd4);
        check("b2b_busy_low", 32'(lowcnt), 32'd1);
        while (sb.size() > 0) void'(sb.pop_front());
        @(negedge clk);

        // reset during WAIT discards the pending write
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; be[1] = 4'hF; wdata[1] = 32'h5A5A5A5A;
        @(posedge clk);
        @(negedge clk);
        check("rst_wait_busy", 32'(busy[1]), 32'd1);
        rst_n = 1'b0;
        req[1] = 1'b0;
        #1;
        check("rst_async_busy", 32'(busy[1]), 32'd0);
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack[1] || err[1] || rdata[1] != 32'h0) stray = 1;
        end
        check("rst_no_ack", 32'(stray), 32'd0);
        rst_n = 1'b1;
        do_req(1, 0, 32'h40, 4'h0, 32'h0, 0, 32'h0, "rd40_after_rst");
        do_req(1, 0, 32'h10, 4'h0, 32'h0, 0, 32'h0, "rd10_after_rst");

        // LATENCY=1: ack the cycle after acceptance, busy only that cycle
        do_req(0, 1, 32'h4, 4'hF, 32'h600DF00D, 0, 32'h0, "wr4_l1");
        do_req(0, 0, 32'h4, 4'h0, 32'h0, 0, 32'h600DF00D, "rd4_l1");
        do_req(0, 0, 32'h3004, 4'h0, 32'h0, 1, 32'h0, "rd_ill_l1");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
